// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec/writeback sequencer owning PC and write strobes
// Optional: define INSTR_SEQ_COND_EXEC_EN to enable ARM condition-code evaluation.
module instr_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              dec_en,
  input  logic              stall,
  input  logic [3:0]        flags,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              reg_we,
  output logic              flags_we,
  output logic [ADDR_W-1:0] pc,
  output logic              retire
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0] state;
  logic       cond_pass;
  logic       is_dp;
  logic       is_test_op;

  // Low PC bits are always forced to zero on a load, so they are never read.
  logic [1:0] unused_pc_lsbs;
  assign unused_pc_lsbs = pc_load_val[1:0];

  // Every strobe comes straight from registered state, instr and cond_pass.
  assign imem_req   = (state == S_FETCH);
  assign dec_en     = (state == S_DECODE);
  assign retire     = (state == S_WB);
  assign imem_addr  = pc;
  assign is_dp      = (instr[27:26] == 2'b00);
  assign is_test_op = (instr[24:23] == 2'b10);  // TST/TEQ/CMP/CMN: opcode 10xx
  assign reg_we     = retire & cond_pass & is_dp & ~is_test_op;
  assign flags_we   = retire & cond_pass & is_dp & instr[20];

`ifdef INSTR_SEQ_COND_EXEC_EN
  logic cond_now;
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = flags;

  // ARM condition table over the current NZCV.
  always_comb begin
    cond_now = 1'b0;
    case (instr[31:28])
      4'h0: cond_now = f_z;
      4'h1: cond_now = ~f_z;
      4'h2: cond_now = f_c;
      4'h3: cond_now = ~f_c;
      4'h4: cond_now = f_n;
      4'h5: cond_now = ~f_n;
      4'h6: cond_now = f_v;
      4'h7: cond_now = ~f_v;
      4'h8: cond_now = f_c & ~f_z;
      4'h9: cond_now = ~f_c | f_z;
      4'hA: cond_now = (f_n == f_v);
      4'hB: cond_now = (f_n != f_v);
      4'hC: cond_now = ~f_z & (f_n == f_v);
      4'hD: cond_now = f_z | (f_n != f_v);
      4'hE: cond_now = 1'b1;
      default: cond_now = 1'b0;
    endcase
  end

  // Capture the condition every EXEC cycle; the value from the exit cycle is what WB sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_pass <= 1'b0;
    end else if (state == S_EXEC) begin
      cond_pass <= cond_now;
    end
  end
`else
  logic [3:0] unused_flags;
  assign unused_flags = flags;
  assign cond_pass    = 1'b1;
`endif

  // Main sequencer: state, instruction latch and PC advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      instr <= 32'h0;
      pc    <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (!stall) state <= S_WB;
        end
        default: begin
          state <= S_FETCH;
          if (pc_load && cond_pass) pc <= {pc_load_val[ADDR_W-1:2], 2'b00};
          else                      pc <= pc + ADDR_W'(4);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a reference model
module tb_instr_sequencer;

  localparam int          AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          dec_en;
  logic          stall;
  logic [3:0]    flags;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          reg_we;
  logic          flags_we;
  logic [AW-1:0] pc;
  logic          retire;

  instr_sequencer #(.ADDR_W(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .dec_en(dec_en), .stall(stall), .flags(flags),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .reg_we(reg_we), .flags_we(flags_we), .pc(pc), .retire(retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    bit          rwe;
    bit          fwe;
    int          s;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] pc_model;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef INSTR_SEQ_COND_EXEC_EN
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == c) || (f == f);
`endif
  endfunction

  // Issue one instruction from a FETCH cycle and leave the DUT at the next FETCH.
  task automatic issue(input logic [31:0] word, input logic [3:0] fl, input int d, input int s,
                       input bit pl, input logic [31:0] plv);
    exp_t e;
    bit   cp, dp, tst;
    int   op;
    cp  = cond_ok(word[31:28], fl);
    dp  = (word[27:26] == 2'b00);
    op  = int'(word[24:21]);
    tst = (op >= 8) && (op <= 11);
    e.addr = pc_model;
    e.word = word;
    e.rwe  = cp && dp && !tst;
    e.fwe  = cp && dp && word[20];
    e.s    = s;
    sb.push_back(e);
    if (pl && cp) pc_model = plv & 32'hFFFF_FFFC;
    else          pc_model = pc_model + 32'd4;

    flags = fl; pc_load = pl; pc_load_val = plv;
    imem_ack = 1'b0; imem_rdata = $urandom;
    repeat (d) @(posedge clk) #1;
    imem_ack = 1'b1; imem_rdata = word;
    @(posedge clk) #1;
    imem_ack = 1'b0; imem_rdata = $urandom; stall = (s > 0);
    @(posedge clk) #1;
    for (int i = 0; i < s; i++) begin
      imem_ack = 1'($urandom % 2);
      @(posedge clk) #1;
      stall = (i + 1 < s);
    end
    imem_ack = 1'($urandom % 2);
    @(posedge clk) #1;
    imem_ack = 1'($urandom % 2);
    @(posedge clk) #1;
    imem_ack = 1'b0;
  endtask

  // Monitor: compares what the DUT presents against the front of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_req && sb.size() > 0) chk("fetch_addr", imem_addr, sb[0].addr);
      if (imem_req && imem_ack) ack_cyc = cyc;
      if (dec_en) chk("dec_latency", 32'(cyc - ack_cyc), 32'd1);
      if ((reg_we || flags_we) && !retire) chk("strobe_outside_wb", 32'd1, 32'd0);
      if (retire) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("instr",      instr,               e.word);
          chk("pc_at_wb",   pc,                  e.addr);
          chk("reg_we",     32'(reg_we),         32'(e.rwe));
          chk("flags_we",   32'(flags_we),       32'(e.fwe));
          chk("wb_latency", 32'(cyc - ack_cyc),  32'(3 + e.s));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    flags = 4'h0; pc_load = 1'b0; pc_load_val = 32'h0;
    pc_model = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",       pc,              RESET_PC);
    chk("rst_instr",    instr,           32'h0);
    chk("rst_strobes",  {28'h0, dec_en, reg_we, flags_we, retire}, 32'h0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_rst", 32'(imem_req), 32'd1);
    @(posedge clk) #1;

    // Directed cases.
    issue(32'hE081_0002, 4'h0, 0, 0, 1'b0, 32'h0);          // ADD, immediate ack
    issue(32'hE081_0002, 4'h0, 3, 0, 1'b0, 32'h0);          // delayed ack
    issue(32'h0081_0002, 4'h0, 0, 0, 1'b0, 32'h0);          // ADDEQ, Z=0
    issue(32'h0081_0002, 4'h4, 0, 0, 1'b0, 32'h0);          // ADDEQ, Z=1
    issue(32'hE151_0002, 4'h0, 0, 2, 1'b0, 32'h0);          // CMP with 2 stall cycles
    issue(32'hE081_0002, 4'h0, 0, 0, 1'b1, 32'h0000_0103);  // PC load, low bits dropped
    issue(32'hE081_0002, 4'h0, 0, 0, 1'b1, 32'hFFFF_FFFC);  // jump to top word
    issue(32'hE081_0002, 4'h0, 0, 0, 1'b0, 32'h0);          // wraps to 0
    issue(32'hF081_0002, 4'hF, 1, 1, 1'b1, 32'h0000_0040);  // never-condition

    // Randomized instructions.
    for (int k = 0; k < 150; k++) begin
      issue($urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom % 4) == 0, $urandom);
    end

    // Reset in the middle of EXEC: the interrupted instruction must never retire.
    flags = 4'h0; pc_load = 1'b1; pc_load_val = 32'h0000_0800;
    imem_ack = 1'b1; imem_rdata = 32'hE091_0002;
    @(posedge clk) #1;
    imem_ack = 1'b0; stall = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc",      pc,                              RESET_PC);
    chk("midrst_strobes", {29'h0, reg_we, flags_we, retire}, 32'h0);
    sb.delete();
    pc_model = RESET_PC;
    stall = 1'b0; pc_load = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    issue(32'hE081_0002, 4'h0, 2, 0, 1'b0, 32'h0);
    for (int k = 0; k < 30; k++) begin
      issue($urandom, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            ($urandom % 3) == 0, $urandom);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM that sequences the ARM data-processing datapath: fetches a 32-bit instruction over a request/acknowledge memory port, presents it to the instruction decoder for one decode cycle, holds execute while the datapath stalls, then issues register and flag write strobes and advances the PC. It sits between instruction memory and the decoder/ALU/register-file datapath and is the only block that owns the PC and the write-enable timing.

## Interface
- `ADDR_W`, 32, width of PC and instruction address
- `RESET_PC`, 0, PC value loaded on reset (word aligned)

- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request, high throughout FETCH
- `imem_addr`  out  ADDR_W  fetch address (= `pc`)
- `imem_ack`  in  1  memory returns data this cycle
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`
- `instr`  out  32  latched instruction driven to decoder
- `dec_en`  out  1  decode strobe, high for exactly the DECODE cycle
- `stall`  in  1  datapath not ready; holds EXEC
- `flags`  in  4  current NZCV (bit3 = N … bit0 = V)
- `pc_load`  in  1  execute result targets PC
- `pc_load_val`  in  ADDR_W  new PC when `pc_load`
- `reg_we`  out  1  register-file write strobe (WB cycle)
- `flags_we`  out  1  NZCV write strobe (WB cycle)
- `pc`  out  ADDR_W  current instruction address
- `retire`  out  1  one-cycle pulse per completed instruction

## Operation
- States: FETCH → DECODE → EXEC → WB → FETCH; encoded 2 bits.
- FETCH: `imem_req`=1; on edge with `imem_ack`=1 latch `imem_rdata` into `instr`, go DECODE; else stay, `imem_addr` stable.
- DECODE: `dec_en`=1 for one cycle; always → EXEC.
- EXEC: stay while `stall`=1; → WB on edge with `stall`=0. Condition evaluated here from `instr[31:28]` and `flags`; result registered as `cond_pass`.
- Condition table: standard ARM EQ..LE, 1110 (AL) pass, 1111 always fail.
- WB: `retire`=1. Data-processing = `instr[27:26]`==00. `reg_we` = cond_pass & data-processing & opcode `instr[24:21]` not in 1000–1011 (TST/TEQ/CMP/CMN). `flags_we` = cond_pass & data-processing & `instr[20]`. Non-data-processing words retire as NOPs (no strobes).
- PC update in WB: if `pc_load` & cond_pass, `pc` ← `pc_load_val` with bits[1:0] forced 0; else `pc` ← `pc`+4 modulo 2^ADDR_W (0xFFFFFFFC → 0).
- `pc_load` outside WB is ignored.

## Timing
- Reset (async assert): state FETCH, `pc`=RESET_PC, `instr`=0, `dec_en`/`reg_we`/`flags_we`/`retire`=0; `imem_req`=1 from first cycle after release.
- `imem_req`, `dec_en`, `reg_we`, `flags_we`, `retire` are decoded from registered state only (no input→output combinational path except none).
- Minimum throughput: 4 cycles per instruction (ack in first FETCH cycle, no stall). Each ack wait or stall cycle adds 1.
- Reset during any state: outstanding fetch abandoned, any late `imem_ack` after release sampled only as a new FETCH response; no strobe issued for the interrupted instruction.
- `imem_ack` while not in FETCH: ignored.

## Configuration
- `INSTR_SEQ_COND_EXEC_EN` defined: condition table as above; failed condition suppresses `reg_we`, `flags_we` and `pc_load`, instruction still retires.
- Not defined: `cond_pass` tied 1 (every instruction treated as AL, including cond 1111); no flag-dependent logic generated; `flags` unused.

## Test plan
- Reset, ack immediate, `imem_rdata`=0xE0810002 (ADD r0,r1,r2) → `imem_addr`=0, `dec_en` cycle 2, `reg_we`+`retire` cycle 4, `flags_we`=0, `pc`=4 after WB.
- Ack delayed 3 cycles → `imem_req` high and `imem_addr` stable 4 cycles, `retire` at cycle 7.
- 0x00810002 (ADDEQ) with `flags`=0000 → `reg_we`=0, `retire`=1, `pc`+4; repeat with `flags`=0100 → `reg_we`=1 (macro undefined: `reg_we`=1 both times).
- 0xE1510002 (CMP r1,r2, S=1) → `reg_we`=0, `flags_we`=1; `stall` held 2 cycles in EXEC → WB delayed 2 cycles.
- `pc_load`=1, `pc_load_val`=0x103 in WB → next `imem_addr`=0x100; start at `pc`=0xFFFFFFFC without load → next `pc`=0.
- Assert `rst_n` low mid-EXEC, release, ack → no `reg_we`/`retire` for old instruction, fetch restarts at RESET_PC.
